// File: rtl/bp_pkg.sv
// Shared decode constants, counter-init helper and instruction decoder
// for the branch predictor.
package bp_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Weakly not-taken: one below the counter midpoint.
  function automatic int cnt_init(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  typedef struct packed {
    logic        br;
    logic        jal;
    logic [31:0] imm;
  } dec_t;

  // Classify the word and extract its sign-extended B/J immediate.
  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d = '0;
    if (ins[6:0] == OP_BRANCH) begin
      case (ins[14:12])
        F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: d.br = 1'b1;
        default:                                          d.br = 1'b0;
      endcase
    end
    d.jal = (ins[6:0] == OP_JAL);
    if (d.br)
      d.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    else if (d.jal)
      d.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    return d;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: flop array of saturating counters,
// one combinational read port, one registered write port.
module bp_pht
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [CNT_W-1:0] o_rd_cnt,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init(CNT_W));

  logic [CNT_W-1:0] r_cnt [ENTRIES];

  // The read sees the array before this edge's write lands, which gives
  // read-before-write on a same-cycle lookup and update.
  assign o_rd_cnt = r_cnt[i_rd_idx];

  // Saturating increment/decrement of the addressed counter.
  // NOTE: the array is a flop bank, so every entry takes the reset value;
  // a RAM macro could not be cleared this way.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= CNT_INIT;
    end else if (i_wr_en) begin
      if (i_wr_taken) begin
        if (r_cnt[i_wr_idx] != CNT_MAX) r_cnt[i_wr_idx] <= r_cnt[i_wr_idx] + 1'b1;
      end else begin
        if (r_cnt[i_wr_idx] != '0) r_cnt[i_wr_idx] <= r_cnt[i_wr_idx] - 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: decodes B/J instructions, computes the
// target and predicts direction (static BTFN or dynamic PHT), with a
// saturating mispredict counter.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int MODE    = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_ins,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic        i_upd_mispred,
  output logic        o_valid,
  output logic        o_br,
  output logic        o_jal,
  output logic [31:0] o_imm,
  output logic        o_pred_taken,
  output logic [31:0] o_target,
  output logic [15:0] o_miss_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic [CNT_W-1:0] w_cnt;
  dec_t             w_dec;
  logic             w_pred;
  logic             w_unused;

  logic        r_valid;
  logic        r_br;
  logic        r_jal;
  logic [31:0] r_imm;
  logic        r_pred;
  logic [31:0] r_target;
  logic [15:0] r_miss_cnt;

  // Word-aligned PC bits select the counter for both lookup and update.
  assign w_rd_idx = i_pc[IDX_W+1:2];
  assign w_wr_idx = i_upd_pc[IDX_W+1:2];
  assign w_dec    = decode(i_ins);
  assign w_unused = ^{i_upd_pc[31:IDX_W+2], i_upd_pc[1:0], w_cnt};

  bp_pht #(
    .ENTRIES (ENTRIES),
    .CNT_W   (CNT_W),
    .IDX_W   (IDX_W)
  ) u_pht (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rd_idx   (w_rd_idx),
    .o_rd_cnt   (w_cnt),
    .i_wr_en    (i_upd_valid),
    .i_wr_idx   (w_wr_idx),
    .i_wr_taken (i_upd_taken)
  );

  // Direction: JAL always taken, branches by counter MSB or offset sign.
  // NOTE: every path assigns w_pred, so no latch is inferred.
  always_comb begin
    w_pred = 1'b0;
    if (w_dec.jal)
      w_pred = 1'b1;
    else if (w_dec.br)
      w_pred = (MODE == 1) ? w_cnt[CNT_W-1] : w_dec.imm[31];
  end

  // Lookup result register; payload holds when no lookup is presented.
  // NOTE: state is written with <= so all flops update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid  <= 1'b0;
      r_br     <= 1'b0;
      r_jal    <= 1'b0;
      r_imm    <= '0;
      r_pred   <= 1'b0;
      r_target <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_br     <= w_dec.br;
        r_jal    <= w_dec.jal;
        r_imm    <= w_dec.imm;
        r_pred   <= w_pred;
        r_target <= i_pc + w_dec.imm;
      end
    end
  end

  // Saturating count of resolved mispredictions.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_miss_cnt <= '0;
    else if (i_upd_valid && i_upd_mispred && r_miss_cnt != 16'hFFFF)
      r_miss_cnt <= r_miss_cnt + 16'd1;
  end

  assign o_valid      = r_valid;
  assign o_br         = r_br;
  assign o_jal        = r_jal;
  assign o_imm        = r_imm;
  assign o_pred_taken = r_pred;
  assign o_target     = r_target;
  assign o_miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: one dynamic (MODE=1) and one static (MODE=0) instance
// share stimulus; a vector table covers decode/target/prediction and
// hand sequences cover counters, collisions, miss count and reset.
module tb_branch_predictor;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_pc = '0;
  logic [31:0] i_ins = '0;
  logic        i_upd_valid = 1'b0;
  logic [31:0] i_upd_pc = '0;
  logic        i_upd_taken = 1'b0;
  logic        i_upd_mispred = 1'b0;

  logic        d_valid, d_br, d_jal, d_pred;
  logic [31:0] d_imm, d_target;
  logic [15:0] d_miss;
  logic        s_valid, s_br, s_jal, s_pred;
  logic [31:0] s_imm, s_target;
  logic [15:0] s_miss;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  branch_predictor #(.ENTRIES(16), .CNT_W(2), .MODE(1)) u_dyn (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_pc(i_pc), .i_ins(i_ins),
    .i_upd_valid(i_upd_valid), .i_upd_pc(i_upd_pc), .i_upd_taken(i_upd_taken),
    .i_upd_mispred(i_upd_mispred), .o_valid(d_valid), .o_br(d_br), .o_jal(d_jal),
    .o_imm(d_imm), .o_pred_taken(d_pred), .o_target(d_target), .o_miss_cnt(d_miss)
  );

  branch_predictor #(.ENTRIES(16), .CNT_W(2), .MODE(0)) u_sta (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_pc(i_pc), .i_ins(i_ins),
    .i_upd_valid(i_upd_valid), .i_upd_pc(i_upd_pc), .i_upd_taken(i_upd_taken),
    .i_upd_mispred(i_upd_mispred), .o_valid(s_valid), .o_br(s_br), .o_jal(s_jal),
    .o_imm(s_imm), .o_pred_taken(s_pred), .o_target(s_target), .o_miss_cnt(s_miss)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        br;
    logic        jal;
    logic [31:0] imm;
    logic [31:0] target;
    logic        pred_dyn;
    logic        pred_sta;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input int imm);
    logic [31:0] i;
    i = imm;
    return {i[12], i[10:5], 5'd2, 5'd1, f3, i[4:1], i[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm);
    logic [31:0] i;
    i = imm;
    return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'b1101111};
  endfunction

  // Inputs are driven 1 time unit after a rising edge; results are checked
  // 1 time unit after the following edge.
  task automatic lookup(input logic [31:0] pc, input logic [31:0] ins);
    i_valid = 1'b1; i_pc = pc; i_ins = ins;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic mis);
    i_upd_valid = 1'b1; i_upd_pc = pc; i_upd_taken = taken; i_upd_mispred = mis;
    @(posedge i_clk); #1;
    i_upd_valid = 1'b0; i_upd_mispred = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dvalid"}, 32'(d_valid), 0);
    check({tag, "_dbr"},    32'(d_br),    0);
    check({tag, "_djal"},   32'(d_jal),   0);
    check({tag, "_dpred"},  32'(d_pred),  0);
    check({tag, "_dimm"},   d_imm,        0);
    check({tag, "_dtgt"},   d_target,     0);
    check({tag, "_dmiss"},  32'(d_miss),  0);
    check({tag, "_svalid"}, 32'(s_valid), 0);
    check({tag, "_spred"},  32'(s_pred),  0);
    check({tag, "_stgt"},   s_target,     0);
    check({tag, "_smiss"},  32'(s_miss),  0);
  endtask

  initial begin
    // name, pc, ins, br, jal, imm, target, pred_dyn, pred_sta
    vecs[0]  = '{"beq_m8",    32'h0000_0100, 32'hFE00_0CE3,       1, 0, 32'hFFFF_FFF8, 32'h0000_00F8, 0, 1};
    vecs[1]  = '{"jal_wrap",  32'hFFFF_F800, enc_j(2048),         0, 1, 32'h0000_0800, 32'h0000_0000, 1, 1};
    vecs[2]  = '{"bne_p16",   32'h0000_0200, enc_b(3'b001, 16),   1, 0, 32'h0000_0010, 32'h0000_0210, 0, 0};
    vecs[3]  = '{"bne_m16",   32'h0000_0200, enc_b(3'b001, -16),  1, 0, 32'hFFFF_FFF0, 32'h0000_01F0, 0, 1};
    vecs[4]  = '{"add_op",    32'h0000_0300, 32'h00B5_0533,       0, 0, 32'h0000_0000, 32'h0000_0300, 0, 0};
    vecs[5]  = '{"br_f3_010", 32'h0000_0304, enc_b(3'b010, -8),   0, 0, 32'h0000_0000, 32'h0000_0304, 0, 0};
    vecs[6]  = '{"br_f3_011", 32'h0000_0308, enc_b(3'b011, -8),   0, 0, 32'h0000_0000, 32'h0000_0308, 0, 0};
    vecs[7]  = '{"bgeu_max",  32'h0000_1000, enc_b(3'b111, 4094), 1, 0, 32'h0000_0FFE, 32'h0000_1FFE, 0, 0};
    vecs[8]  = '{"blt_min",   32'h0000_0000, enc_b(3'b100, -4096),1, 0, 32'hFFFF_F000, 32'hFFFF_F000, 0, 1};
    vecs[9]  = '{"jal_min",   32'h0010_0000, enc_j(-1048576),     0, 1, 32'hFFF0_0000, 32'h0000_0000, 1, 1};
    vecs[10] = '{"jal_max",   32'h0000_0000, enc_j(1048574),      0, 1, 32'h000F_FFFE, 32'h000F_FFFE, 1, 1};
    vecs[11] = '{"jalr_op",   32'h0000_0400, 32'h0000_8067,       0, 0, 32'h0000_0000, 32'h0000_0400, 0, 0};

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check_all_zero("rst");
    i_rst_n = 1'b1;

    // Table: decode, immediate, target and prediction with fresh counters
    for (int k = 0; k < 12; k++) begin
      lookup(vecs[k].pc, vecs[k].ins);
      check({vecs[k].name, "_valid"},  32'(d_valid),  1);
      check({vecs[k].name, "_br"},     32'(d_br),     32'(vecs[k].br));
      check({vecs[k].name, "_jal"},    32'(d_jal),    32'(vecs[k].jal));
      check({vecs[k].name, "_imm"},    d_imm,         vecs[k].imm);
      check({vecs[k].name, "_target"}, d_target,      vecs[k].target);
      check({vecs[k].name, "_pdyn"},   32'(d_pred),   32'(vecs[k].pred_dyn));
      check({vecs[k].name, "_psta"},   32'(s_pred),   32'(vecs[k].pred_sta));
      check({vecs[k].name, "_ssame"},  s_target,      vecs[k].target);
    end

    // Idle cycle: valid drops, payload holds the last lookup
    @(posedge i_clk); #1;
    check("hold_valid",  32'(d_valid), 0);
    check("hold_imm",    d_imm,        32'h0000_0000);
    check("hold_target", d_target,     32'h0000_0400);
    lookup(32'h0000_1000, enc_b(3'b111, 4094));
    @(posedge i_clk); #1;
    check("hold2_imm",    d_imm,        32'h0000_0FFE);
    check("hold2_target", d_target,     32'h0000_1FFE);
    check("hold2_br",     32'(d_br),    1);

    // Counter saturation high: init 1, three taken -> 3
    repeat (3) upd(32'h0000_0100, 1'b1, 1'b0);
    lookup(32'h0000_0100, 32'hFE00_0CE3);
    check("sat3_pred", 32'(d_pred), 1);
    check("sat3_sta",  32'(s_pred), 1);
    upd(32'h0000_0100, 1'b0, 1'b0);
    lookup(32'h0000_0100, 32'hFE00_0CE3);
    check("cnt2_pred", 32'(d_pred), 1);
    upd(32'h0000_0100, 1'b0, 1'b0);
    lookup(32'h0000_0100, 32'hFE00_0CE3);
    check("cnt1_pred", 32'(d_pred), 0);
    // Saturation low: down to 0 and hold, then climb back
    repeat (3) upd(32'h0000_0100, 1'b0, 1'b0);
    upd(32'h0000_0100, 1'b1, 1'b0);
    lookup(32'h0000_0100, 32'hFE00_0CE3);
    check("sat0_up1_pred", 32'(d_pred), 0);
    upd(32'h0000_0100, 1'b1, 1'b0);
    lookup(32'h0000_0100, 32'hFE00_0CE3);
    check("sat0_up2_pred", 32'(d_pred), 1);
    // Update on an aliasing PC (same index, different tag bits)
    upd(32'h0000_0140, 1'b0, 1'b0);
    lookup(32'h0000_0100, 32'hFE00_0CE3);
    check("alias_pred", 32'(d_pred), 0);

    // Same-edge lookup and taken update on index 5 (counter 1)
    i_valid = 1'b1; i_pc = 32'h0000_0014; i_ins = 32'hFE00_0CE3;
    i_upd_valid = 1'b1; i_upd_pc = 32'h0000_0014; i_upd_taken = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_upd_valid = 1'b0;
    check("rbw_first", 32'(d_pred), 0);
    lookup(32'h0000_0014, 32'hFE00_0CE3);
    check("rbw_second", 32'(d_pred), 1);

    // Miss counter: only valid & mispred edges count
    check("miss_zero", 32'(d_miss), 0);
    upd(32'h0000_003C, 1'b0, 1'b1);
    upd(32'h0000_003C, 1'b0, 1'b0);
    i_upd_mispred = 1'b1;
    @(posedge i_clk); #1;
    i_upd_mispred = 1'b0;
    upd(32'h0000_003C, 1'b1, 1'b1);
    upd(32'h0000_003C, 1'b0, 1'b1);
    check("miss_three", 32'(d_miss), 3);
    i_upd_valid = 1'b1; i_upd_pc = 32'h0000_003C; i_upd_mispred = 1'b1;
    repeat (32'h10002) @(posedge i_clk);
    #1;
    i_upd_valid = 1'b0; i_upd_mispred = 1'b0;
    check("miss_sat",     32'(d_miss), 32'h0000_FFFF);
    check("miss_sat_sta", 32'(s_miss), 32'h0000_FFFF);

    // Asynchronous reset between edges, with a lookup in flight
    lookup(32'h0000_0014, 32'hFE00_0CE3);
    check("pre_rst_pred", 32'(d_pred), 1);
    i_valid = 1'b1; i_pc = 32'h0000_0200; i_ins = enc_b(3'b001, 16);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_all_zero("async");
    i_valid = 1'b0;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check("post_rst_valid", 32'(d_valid), 0);
    // Counters re-initialised: index 5 back to weakly not-taken
    lookup(32'h0000_0014, 32'hFE00_0CE3);
    check("post_rst_valid2", 32'(d_valid), 1);
    check("post_rst_pred",   32'(d_pred),  0);
    check("post_rst_target", d_target,     32'h0000_000C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16: pattern-history-table (PHT) entry count; SHALL be a power of two, 2..1024.
REQ-002 Parameter CNT_W, default 2: saturating counter width, 1..4.
REQ-003 Parameter MODE, default 1: 0 = static backward-taken/forward-not-taken; 1 = dynamic PHT.
REQ-004 i_clk  in  1  single clock, rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_valid  in  1  fetch-stage lookup request.
REQ-007 i_pc  in  32  PC of the fetched instruction.
REQ-008 i_ins  in  32  fetched instruction word.
REQ-009 i_upd_valid  in  1  branch resolution update strobe.
REQ-010 i_upd_pc  in  32  PC of the resolved conditional branch.
REQ-011 i_upd_taken  in  1  resolved direction.
REQ-012 i_upd_mispred  in  1  resolution disagreed with the issued prediction.
REQ-013 o_valid  out  1  registered lookup result valid.
REQ-014 o_br  out  1  instruction is a conditional branch.
REQ-015 o_jal  out  1  instruction is JAL.
REQ-016 o_imm  out  32  sign-extended B- or J-type immediate.
REQ-017 o_pred_taken  out  1  predicted taken.
REQ-018 o_target  out  32  i_pc + o_imm.
REQ-019 o_miss_cnt  out  16  saturating mispredict count.

Function
REQ-020 Decode: o_br SHALL be 1 iff opcode = 1100011 and funct3 is one of 000, 001, 100, 101, 110, 111; o_jal SHALL be 1 iff opcode = 1101111; every other encoding SHALL give o_br = o_jal = 0.
REQ-021 Immediate: o_br SHALL select {ins[31] x20, ins[7], ins[30:25], ins[11:8], 0}; o_jal SHALL select {ins[31] x12, ins[19:12], ins[20], ins[30:21], 0}; otherwise o_imm = 0.
REQ-022 Target arithmetic SHALL be modulo 2^32, with wrap-around and no flag.
REQ-023 Index SHALL be pc[IDX_W+1:2], where IDX_W = log2(ENTRIES); the same index function SHALL apply to i_upd_pc.
REQ-024 Prediction: JAL SHALL always predict taken; a non-branch SHALL predict 0; a branch with MODE = 1 SHALL use the counter MSB; a branch with MODE = 0 SHALL use the immediate sign bit.
REQ-025 Latency: i_valid and its inputs sampled at edge N SHALL produce all outputs at edge N+1; with i_valid = 0 at edge N, o_valid = 0 after edge N+1 and the other outputs SHALL hold their previous values.
REQ-026 Update: when i_upd_valid = 1 at an edge, the indexed counter SHALL increment (if i_upd_taken) or decrement (otherwise), saturating at 2^CNT_W-1 and at 0; the update SHALL apply in both modes.
REQ-027 Same-cycle lookup and update on the same index SHALL return the pre-update counter value; the update SHALL still take effect.
REQ-028 o_miss_cnt SHALL increment on each i_upd_valid & i_upd_mispred edge and saturate at 0xFFFF.
REQ-029 Updates SHALL be accepted every cycle without backpressure; the block SHALL have no stall output.

Reset
REQ-030 While i_rst_n = 0: o_valid, o_br, o_jal, o_pred_taken = 0; o_imm, o_target = 0; o_miss_cnt = 0; all counters = 2^(CNT_W-1)-1 (weakly not-taken).
REQ-031 Assertion mid-operation SHALL clear state immediately, without waiting for a clock edge; a lookup in flight SHALL be discarded; the first lookup SHALL be sampled at the first rising edge after deassertion.

Structure
REQ-032 Shared package bp_pkg SHALL hold the opcode constants (OP_BRANCH, OP_JAL), the funct3 constants, and the counter-init expression.
REQ-033 PHT storage and saturating update logic SHALL be a sub-module bp_pht (flip-flop array, one read port, one write port, read-before-write).

Verification
REQ-034 Reset, then look up PC 0x100 with BEQ, imm -8, MODE = 1 -> next cycle o_br = 1, o_imm = 0xFFFFFFF8, o_target = 0x000000F8, o_pred_taken = 0.
REQ-035 Three taken updates to PC 0x100, then a lookup -> o_pred_taken = 1 and the counter reads 3 (saturated); one not-taken update -> counter reads 2 and the prediction is still taken.
REQ-036 JAL with imm +2048 at PC 0xFFFFF800 -> o_jal = 1, o_pred_taken = 1, o_target = 0x00000000 (wrap-around).
REQ-037 Same-edge lookup and taken update on index 5, counter 1 -> the lookup returns not-taken; the following lookup returns taken.
REQ-038 MODE = 0, BNE with imm +16 -> not-taken; BNE with imm -16 -> taken; an opcode 0110011 word -> o_br = o_jal = 0.
REQ-039 Drive 0x10005 mispredict updates -> o_miss_cnt = 0xFFFF; then pulse i_rst_n low between clock edges -> all outputs are 0 before the next edge.
